// File: rtl/lt24_bus_decoder.sv
// lt24_bus_decoder: passive decoder of the LT24 (ILI9341) 16-bit write bus: commands, address window, pixel strobes.
// Optional: define LT24_DECODER_CHECKSUM_EN to add the frame_sum output (wrapping sum of pixel data per frame).
module lt24_bus_decoder #(
    parameter int WIDTH_DEF  = 240,
    parameter int HEIGHT_DEF = 320
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        LT24CS_n,
    input  logic        LT24Wr_n,
    input  logic        LT24Rd_n,
    input  logic        LT24RS,
    input  logic        LT24Reset_n,
    input  logic [15:0] LT24Data,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic        pixel_valid,
    output logic [8:0]  pixel_x,
    output logic [8:0]  pixel_y,
    output logic [15:0] pixel_data,
    output logic        frame_done,
`ifdef LT24_DECODER_CHECKSUM_EN
    output logic [15:0] frame_sum,
`endif
    output logic        protocol_error
);

    typedef enum logic [2:0] {IDLE, CASET, PASET, RAMWR, SKIP} state_t;

    localparam logic [7:0]  CMD_CASET  = 8'h2A;
    localparam logic [7:0]  CMD_PASET  = 8'h2B;
    localparam logic [7:0]  CMD_RAMWR  = 8'h2C;
    localparam logic [7:0]  CMD_RAMWRC = 8'h3C;
    localparam logic [15:0] X_LIM      = 16'(WIDTH_DEF);
    localparam logic [15:0] Y_LIM      = 16'(HEIGHT_DEF);
    localparam logic [15:0] XE_DEF     = 16'(WIDTH_DEF - 1);
    localparam logic [15:0] YE_DEF     = 16'(HEIGHT_DEF - 1);

    state_t      state_q;
    logic        cs_n_q;
    logic        wr_n_q;
    logic        rd_n_q;
    logic        rs_q;
    logic        lrst_n_q;
    logic [15:0] data_q;

    logic [1:0]  pcnt_q;
    logic [7:0]  p0_q;
    logic [7:0]  p1_q;
    logic [7:0]  p2_q;

    logic [15:0] xs_q;
    logic [15:0] xe_q;
    logic [15:0] ys_q;
    logic [15:0] ye_q;
    logic        xv_q;
    logic        yv_q;
    logic [15:0] pos_x_q;
    logic [15:0] pos_y_q;
    logic [15:0] pos_x_d;
    logic [15:0] pos_y_d;

    logic        cmd_valid_q;
    logic [7:0]  cmd_code_q;
    logic        pixel_valid_q;
    logic [8:0]  pix_x_q;
    logic [8:0]  pix_y_q;
    logic [15:0] pix_data_q;
    logic        frame_done_q;
    logic        err_q;

    logic        wr_evt;
    logic [15:0] par_start;
    logic [15:0] par_end;
    logic        x_ok;
    logic        y_ok;
    logic        last_col;
    logic        last_row;

`ifdef LT24_DECODER_CHECKSUM_EN
    logic [15:0] sum_acc_q;
    logic [15:0] sum_acc_d;
    logic [15:0] frame_sum_q;
    assign sum_acc_d = sum_acc_q + data_q;
    assign frame_sum = frame_sum_q;
`endif

    // A write event is the rising edge of Wr_n seen between the input register and the pin.
    assign wr_evt    = ~wr_n_q & LT24Wr_n & ~cs_n_q;
    assign par_start = {p0_q, p1_q};
    assign par_end   = {p2_q, data_q[7:0]};
    assign x_ok      = (par_start <= par_end) && (par_end < X_LIM);
    assign y_ok      = (par_start <= par_end) && (par_end < Y_LIM);
    assign last_col  = (pos_x_q == xe_q);
    assign last_row  = (pos_y_q == ye_q);
    assign pos_x_d   = last_col ? xs_q : pos_x_q + 16'd1;
    assign pos_y_d   = last_col ? (last_row ? ys_q : pos_y_q + 16'd1) : pos_y_q;

    assign cmd_valid      = cmd_valid_q;
    assign cmd_code       = cmd_code_q;
    assign pixel_valid    = pixel_valid_q;
    assign pixel_x        = pix_x_q;
    assign pixel_y        = pix_y_q;
    assign pixel_data     = pix_data_q;
    assign frame_done     = frame_done_q;
    assign protocol_error = err_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cs_n_q        <= 1'b1;
            wr_n_q        <= 1'b1;
            rd_n_q        <= 1'b1;
            rs_q          <= 1'b0;
            lrst_n_q      <= 1'b1;
            data_q        <= 16'h0000;
            pcnt_q        <= 2'd0;
            p0_q          <= 8'h00;
            p1_q          <= 8'h00;
            p2_q          <= 8'h00;
            xs_q          <= 16'h0000;
            xe_q          <= XE_DEF;
            ys_q          <= 16'h0000;
            ye_q          <= YE_DEF;
            xv_q          <= 1'b1;
            yv_q          <= 1'b1;
            pos_x_q       <= 16'h0000;
            pos_y_q       <= 16'h0000;
            cmd_valid_q   <= 1'b0;
            cmd_code_q    <= 8'h00;
            pixel_valid_q <= 1'b0;
            pix_x_q       <= 9'd0;
            pix_y_q       <= 9'd0;
            pix_data_q    <= 16'h0000;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
`ifdef LT24_DECODER_CHECKSUM_EN
            sum_acc_q     <= 16'h0000;
            frame_sum_q   <= 16'h0000;
`endif
        end else begin
            cs_n_q        <= LT24CS_n;
            wr_n_q        <= LT24Wr_n;
            rd_n_q        <= LT24Rd_n;
            rs_q          <= LT24RS;
            lrst_n_q      <= LT24Reset_n;
            data_q        <= LT24Data;
            cmd_valid_q   <= 1'b0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;

            // Panel reset overrides any write event detected in the same cycle.
            if (!lrst_n_q) begin
                state_q <= IDLE;
                pcnt_q  <= 2'd0;
                xs_q    <= 16'h0000;
                xe_q    <= XE_DEF;
                ys_q    <= 16'h0000;
                ye_q    <= YE_DEF;
                xv_q    <= 1'b1;
                yv_q    <= 1'b1;
                pos_x_q <= 16'h0000;
                pos_y_q <= 16'h0000;
                pix_x_q <= 9'd0;
                pix_y_q <= 9'd0;
                err_q   <= 1'b0;
`ifdef LT24_DECODER_CHECKSUM_EN
                sum_acc_q   <= 16'h0000;
                frame_sum_q <= 16'h0000;
`endif
            end else if (wr_evt) begin
                if (!rd_n_q) begin
                    err_q <= 1'b1;
                end
                if (!rs_q) begin
                    cmd_valid_q <= 1'b1;
                    cmd_code_q  <= data_q[7:0];
                    pcnt_q      <= 2'd0;
                    case (data_q[7:0])
                        CMD_CASET:  state_q <= CASET;
                        CMD_PASET:  state_q <= PASET;
                        CMD_RAMWR: begin
                            state_q <= RAMWR;
                            pos_x_q <= xs_q;
                            pos_y_q <= ys_q;
                            pix_x_q <= xs_q[8:0];
                            pix_y_q <= ys_q[8:0];
                        end
                        CMD_RAMWRC: state_q <= RAMWR;
                        default:    state_q <= SKIP;
                    endcase
                end else begin
                    case (state_q)
                        CASET, PASET: begin
                            pcnt_q <= pcnt_q + 2'd1;
                            case (pcnt_q)
                                2'd0: p0_q <= data_q[7:0];
                                2'd1: p1_q <= data_q[7:0];
                                2'd2: p2_q <= data_q[7:0];
                                default: begin
                                    // An out-of-range window is still committed; it only blocks pixels.
                                    state_q <= IDLE;
                                    if (state_q == CASET) begin
                                        xs_q <= par_start;
                                        xe_q <= par_end;
                                        xv_q <= x_ok;
                                        if (!x_ok) err_q <= 1'b1;
                                    end else begin
                                        ys_q <= par_start;
                                        ye_q <= par_end;
                                        yv_q <= y_ok;
                                        if (!y_ok) err_q <= 1'b1;
                                    end
                                end
                            endcase
                        end
                        RAMWR: begin
                            if (xv_q && yv_q) begin
                                pixel_valid_q <= 1'b1;
                                pix_x_q       <= pos_x_q[8:0];
                                pix_y_q       <= pos_y_q[8:0];
                                pix_data_q    <= data_q;
                                frame_done_q  <= last_col && last_row;
                                pos_x_q       <= pos_x_d;
                                pos_y_q       <= pos_y_d;
`ifdef LT24_DECODER_CHECKSUM_EN
                                if (last_col && last_row) begin
                                    frame_sum_q <= sum_acc_d;
                                    sum_acc_q   <= 16'h0000;
                                end else begin
                                    sum_acc_q   <= sum_acc_d;
                                end
`endif
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_lt24_bus_decoder.sv
// Scoreboard bench for lt24_bus_decoder: randomized bus traffic against a behavioural window/pixel model.
module tb_lt24_bus_decoder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        LT24CS_n, LT24Wr_n, LT24Rd_n, LT24RS, LT24Reset_n;
    logic [15:0] LT24Data;
    logic        cmd_valid, pixel_valid, frame_done, protocol_error;
    logic [7:0]  cmd_code;
    logic [8:0]  pixel_x, pixel_y;
    logic [15:0] pixel_data;
`ifdef LT24_DECODER_CHECKSUM_EN
    logic [15:0] frame_sum;
`endif

    always #5 clock = ~clock;

    lt24_bus_decoder dut (
        .clock(clock), .reset_n(reset_n),
        .LT24CS_n(LT24CS_n), .LT24Wr_n(LT24Wr_n), .LT24Rd_n(LT24Rd_n),
        .LT24RS(LT24RS), .LT24Reset_n(LT24Reset_n), .LT24Data(LT24Data),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_data(pixel_data), .frame_done(frame_done),
`ifdef LT24_DECODER_CHECKSUM_EN
        .frame_sum(frame_sum),
`endif
        .protocol_error(protocol_error)
    );

    typedef struct {
        bit          is_pix;
        logic [7:0]  code;
        logic [8:0]  x;
        logic [8:0]  y;
        logic [15:0] d;
        bit          fd;
        bit          err;
        logic [15:0] fsum;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Behavioural reference: mode 0 none, 1 column params, 2 page params, 3 pixel data, 4 discard.
    int mode;
    int par[$];
    int xs, xe, ys, ye, px, py;
    bit xv, yv, m_err;
    int acc, fsum;

    task automatic model_reset();
        mode = 0; par.delete();
        xs = 0; xe = 239; ys = 0; ye = 319; xv = 1; yv = 1;
        px = 0; py = 0; m_err = 0; acc = 0; fsum = 0;
    endtask

    task automatic model_wr(input bit rs, input logic [15:0] d, input bit cs, input bit rd);
        exp_t e;
        int s, en;
        bit ok;
        if (cs) return;
        if (!rd) m_err = 1;
        e.is_pix = 0; e.code = d[7:0]; e.x = 0; e.y = 0; e.d = d; e.fd = 0; e.fsum = 0;
        if (!rs) begin
            par.delete();
            case (d[7:0])
                8'h2A: mode = 1;
                8'h2B: mode = 2;
                8'h2C: begin mode = 3; px = xs; py = ys; end
                8'h3C: mode = 3;
                default: mode = 4;
            endcase
            e.err = m_err;
            q.push_back(e);
        end else if (mode == 1 || mode == 2) begin
            par.push_back(int'(d[7:0]));
            if (par.size() == 4) begin
                s  = par[0] * 256 + par[1];
                en = par[2] * 256 + par[3];
                ok = (s <= en) && (en < ((mode == 1) ? 240 : 320));
                if (!ok) m_err = 1;
                if (mode == 1) begin xs = s; xe = en; xv = ok; end
                else           begin ys = s; ye = en; yv = ok; end
                mode = 0;
                par.delete();
            end
        end else if (mode == 3) begin
            if (xv && yv) begin
                e.is_pix = 1;
                e.x  = 9'(px % 512);
                e.y  = 9'(py % 512);
                e.fd = (px == xe) && (py == ye);
                acc  = (acc + int'(d)) % 65536;
                if (e.fd) begin fsum = acc; acc = 0; end
                e.fsum = 16'(fsum);
                e.err  = m_err;
                q.push_back(e);
                if (px == xe) begin
                    px = xs;
                    py = (py == ye) ? ys : (py + 1) % 65536;
                end else begin
                    px = (px + 1) % 65536;
                end
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic bus_wr(input bit rs, input logic [15:0] d, input bit cs = 1'b0, input bit rd = 1'b1);
        @(negedge clock);
        LT24CS_n = cs; LT24RS = rs; LT24Data = d; LT24Rd_n = rd; LT24Wr_n = 1'b0;
        model_wr(rs, d, cs, rd);
        @(negedge clock);
        LT24Wr_n = 1'b1;
    endtask

    task automatic set_win(input logic [7:0] cmd, input int s, input int e);
        bus_wr(1'b0, {8'h00, cmd});
        bus_wr(1'b1, 16'((s >> 8) & 255));
        bus_wr(1'b1, 16'(s & 255));
        bus_wr(1'b1, 16'((e >> 8) & 255));
        bus_wr(1'b1, 16'(e & 255));
    endtask

    task automatic lcd_reset();
        @(negedge clock); LT24Reset_n = 1'b0;
        @(negedge clock); LT24Reset_n = 1'b1;
        model_reset();
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic settle_and_drain(input string name);
        repeat (4) @(negedge clock);
        check(name, q.size(), 0);
    endtask

    // Monitor: every DUT strobe pops one expected event.
    always @(negedge clock) begin
        exp_t e;
        bit ok;
        if (reset_n === 1'b1 && frame_done === 1'b1 && pixel_valid !== 1'b1) begin
            total++; bad++;
            $display("FAIL frame_done_without_pixel frame_done=%b pixel_valid=%b", frame_done, pixel_valid);
        end
        if (reset_n === 1'b1 && (cmd_valid === 1'b1 || pixel_valid === 1'b1)) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe cmd_valid=%b pixel_valid=%b code=%0h x=%0d y=%0d", cmd_valid, pixel_valid, cmd_code, pixel_x, pixel_y);
            end else begin
                e = q.pop_front();
                ok = (pixel_valid == e.is_pix) && (cmd_valid == !e.is_pix) && (protocol_error == e.err);
                if (e.is_pix) begin
                    ok = ok && (pixel_x == e.x) && (pixel_y == e.y) && (pixel_data == e.d) && (frame_done == e.fd);
`ifdef LT24_DECODER_CHECKSUM_EN
                    if (e.fd) ok = ok && (frame_sum == e.fsum);
`endif
                end else begin
                    ok = ok && (cmd_code == e.code) && (frame_done == 1'b0);
                end
                if (!ok) begin
                    bad++;
                    $display("FAIL event got pix=%b cmd=%b code=%0h x=%0d y=%0d d=%0h fd=%b err=%b expected pix=%b code=%0h x=%0d y=%0d d=%0h fd=%b err=%b",
                             pixel_valid, cmd_valid, cmd_code, pixel_x, pixel_y, pixel_data, frame_done, protocol_error,
                             e.is_pix, e.code, e.x, e.y, e.d, e.fd, e.err);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int r, s, e;
        logic [7:0] others [5];
        others[0] = 8'h36; others[1] = 8'h3A; others[2] = 8'h11; others[3] = 8'h29; others[4] = 8'h00;

        reset_n = 1'b0;
        LT24CS_n = 1'b1; LT24Wr_n = 1'b1; LT24Rd_n = 1'b1; LT24RS = 1'b0;
        LT24Reset_n = 1'b1; LT24Data = 16'h0000;
        model_reset();
        repeat (3) @(negedge clock);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_code", cmd_code, 0);
        check("rst_pixel_valid", pixel_valid, 0);
        check("rst_pixel_x", pixel_x, 0);
        check("rst_pixel_y", pixel_y, 0);
        check("rst_pixel_data", pixel_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_protocol_error", protocol_error, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Default window, three pixels along row 0.
        bus_wr(0, 16'h002C);
        bus_wr(1, 16'hF800); bus_wr(1, 16'h07E0); bus_wr(1, 16'h001F);
        settle_and_drain("drain_default_window");

        // 3x2 window with wrap after the last pixel.
        set_win(8'h2A, 10, 12);
        set_win(8'h2B, 5, 6);
        bus_wr(0, 16'h002C);
        for (int i = 0; i < 7; i++) bus_wr(1, 16'(16'h1000 + i));
        settle_and_drain("drain_small_window");

        // Unrelated command with a parameter.
        lcd_reset();
        bus_wr(0, 16'h0036); bus_wr(1, 16'h0048);
        bus_wr(0, 16'h002C); bus_wr(1, 16'hABCD);
        settle_and_drain("drain_skip_cmd");
        check("err_after_skip", protocol_error, 0);

        // Inverted column window.
        set_win(8'h2A, 20, 10);
        settle_and_drain("drain_bad_window");
        check("err_bad_window", protocol_error, 1);
        bus_wr(0, 16'h002C); bus_wr(1, 16'h1234);
        settle_and_drain("drain_blocked_pixel");
        lcd_reset();
        repeat (2) @(negedge clock);
        check("err_cleared_by_lcd_reset", protocol_error, 0);

        // Deselected write, then read-strobe violation.
        bus_wr(0, 16'h002C, 1'b1, 1'b1);
        bus_wr(1, 16'h5555, 1'b1, 1'b1);
        settle_and_drain("drain_cs_high");
        check("err_cs_high", protocol_error, 0);
        bus_wr(1, 16'h0001, 1'b0, 1'b0);
        settle_and_drain("drain_rd_low");
        check("err_rd_low", protocol_error, 1);
        lcd_reset();

        // Column end past the panel width.
        set_win(8'h2A, 0, 240);
        settle_and_drain("drain_x_oob");
        check("err_x_oob", protocol_error, 1);
        lcd_reset();

        // Aborted CASET keeps the previous window.
        set_win(8'h2A, 50, 51);
        set_win(8'h2B, 7, 7);
        bus_wr(0, 16'h002A); bus_wr(1, 16'h0000); bus_wr(1, 16'h0001);
        bus_wr(0, 16'h002C);
        for (int i = 0; i < 3; i++) bus_wr(1, 16'(16'h2000 + i));
        settle_and_drain("drain_abort_caset");

`ifdef LT24_DECODER_CHECKSUM_EN
        lcd_reset();
        set_win(8'h2A, 0, 1);
        set_win(8'h2B, 0, 0);
        bus_wr(0, 16'h002C); bus_wr(1, 16'hFFFF); bus_wr(1, 16'h0002);
        settle_and_drain("drain_checksum");
        check("frame_sum_2x1", frame_sum, 16'h0001);
`endif

        // Randomized traffic.
        lcd_reset();
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 16) begin
                s = $urandom_range(0, (r < 8) ? 236 : 316);
                e = s + $urandom_range(0, 3);
                if ($urandom_range(0, 19) == 0) e = (s > 0) ? s - 1 : 400;
                set_win((r < 8) ? 8'h2A : 8'h2B, s, e);
            end else if (r < 24) bus_wr(0, 16'h002C);
            else if (r < 27) bus_wr(0, 16'h003C);
            else if (r < 31) begin
                bus_wr(0, {8'h00, others[$urandom_range(0, 4)]});
                bus_wr(1, 16'($urandom_range(0, 255)));
            end else if (r < 33) bus_wr($urandom_range(0, 1) == 1, 16'($urandom), 1'b1, 1'b1);
            else if (r < 34) bus_wr(1, 16'($urandom), 1'b0, 1'b0);
            else if (r < 36) lcd_reset();
            else if (r < 38) bus_wr(1, 16'($urandom_range(0, 255)));
            else bus_wr(1, 16'($urandom));
        end
        settle_and_drain("drain_random");

        // Asynchronous reset in the middle of a frame.
        lcd_reset();
        set_win(8'h2A, 30, 31);
        set_win(8'h2B, 40, 41);
        bus_wr(0, 16'h002C); bus_wr(1, 16'h7777);
        settle_and_drain("drain_pre_async");
        check("pre_async_x", pixel_x, 30);
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        check("async_pixel_x", pixel_x, 0);
        check("async_pixel_y", pixel_y, 0);
        check("async_pixel_data", pixel_data, 0);
        model_reset();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        bus_wr(0, 16'h002C); bus_wr(1, 16'h0F0F);
        settle_and_drain("drain_post_async");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lt24_bus_decoder.md
# lt24_bus_decoder

Passive receiver for the LT24 (ILI9341) 16-bit parallel write bus that the display driver produces. It observes LT24CS_n, LT24Wr_n, LT24Rd_n, LT24RS, LT24Reset_n and LT24Data, and decodes command and parameter writes. It reconstructs the column/page address window and emits one pixel strobe per memory-write data word, with the x/y coordinate of that pixel. It sits on the same LT24 nets as the driver, feeding the on-chip display checker and the integrated-design testbench, and it never drives the bus.

## Interface
- WIDTH_DEF, 240: default column count; the reset value of the window is x 0..WIDTH_DEF-1.
- HEIGHT_DEF, 320: default page count; the reset value of the window is y 0..HEIGHT_DEF-1.
- clock  in  1  system clock, same domain as the LT24 driver.
- reset_n  in  1  asynchronous, active-low reset.
- LT24CS_n, LT24Wr_n, LT24Rd_n, LT24RS, LT24Reset_n  in  1 each  observed bus controls.
- LT24Data  in  16  observed data bus.
- cmd_valid  out  1  one-cycle pulse on each command write (RS=0).
- cmd_code  out  8  last command byte, LT24Data[7:0].
- pixel_valid  out  1  one-cycle pulse on each RAMWR data word.
- pixel_x  out  9  column of the current pixel.
- pixel_y  out  9  page of the current pixel.
- pixel_data  out  16  RGB565 word.
- frame_done  out  1  one-cycle pulse, coincident with pixel_valid, on the last pixel of the window.
- protocol_error  out  1  sticky error flag, cleared only by reset_n or by LT24Reset_n low.

## Operation
- All inputs are registered once into *_q. A write event is defined as LT24Wr_n_q=0 and LT24Wr_n=1 at a clock edge, with LT24CS_n_q=0. RS and Data are taken from *_q.
- Write events with CS_n high are ignored.
- FSM states: IDLE, CASET, PASET, RAMWR, SKIP.
- Command write (RS=0): pulse cmd_valid, latch cmd_code, clear the parameter counter, then branch on the byte:
  - 0x2A → CASET
  - 0x2B → PASET
  - 0x2C → RAMWR; load pixel_x=xs and pixel_y=ys
  - 0x3C (RAMWR continue) → RAMWR, keeping the current position
  - any other byte → SKIP
- CASET/PASET parameter writes (RS=1): four bytes, Data[7:0], MSB first: start_hi, start_lo, end_hi, end_lo. After the 4th byte, commit xs/xe (or ys/ye) and go to IDLE. Extra parameters in IDLE are ignored.
- RAMWR data write (RS=1):
  - Pulse pixel_valid and present pixel_x, pixel_y and Data.
  - Then advance. If x==xe: x←xs and y advances; if y==ye as well, y←ys and frame_done pulses with this pixel. Otherwise x←x+1.
- SKIP: parameters are discarded; the next command write re-dispatches.
- protocol_error sets on any of:
  - a write event with LT24Rd_n_q=0;
  - a committed window with start>end, or with end ≥ WIDTH_DEF (x) or end ≥ HEIGHT_DEF (y). The window is still committed.
  - RAMWR data arriving while the window is invalid. No pixel_valid is issued in that case.
- Arithmetic: parameters are 16-bit internally; pixel_x and pixel_y are the low 9 bits. A committed window always sets validity from the full 16-bit comparison.
- LT24Reset_n_q=0: FSM→IDLE, window→defaults, position→(0,0), protocol_error cleared. This takes priority over any same-cycle write event.

## Timing
- Reset values: cmd_valid=0, cmd_code=0x00, pixel_valid=0, pixel_x=0, pixel_y=0, pixel_data=0, frame_done=0, protocol_error=0, FSM=IDLE.
- Latency: outputs update at the clock edge where the write event is detected, i.e. one edge after LT24Wr_n rises at the input pins (input register) plus the detecting edge.
- All pulses are exactly one cycle wide.
- Minimum Wr_n low time is 1 clock and minimum high time is 1 clock. Back-to-back events every 2 clocks are decoded without loss.
- A command arriving mid-CASET/PASET aborts the partial parameter set; the old window is retained.
- reset_n asserted mid-frame clears the frame immediately and asynchronously. No frame_done is issued.

## Configuration
- LT24_DECODER_CHECKSUM_EN defined:
  - adds output frame_sum (16 bits), the wrapping sum of pixel_data over the frame;
  - frame_sum is updated on frame_done to include the last pixel, and the accumulator then restarts at 0;
  - reset value 0; also cleared by LT24Reset_n low.
- Undefined: no frame_sum port and no accumulator logic. All other behaviour is identical.

## Test plan
- Reset, then RAMWR (0x2C) followed by 3 words 0xF800, 0x07E0, 0x001F → pixel_valid at (0,0), (1,0), (2,0) with those data; frame_done never asserts.
- CASET 0,10,0,12 and PASET 0,5,0,6, then RAMWR with 6 words → coordinates (10,5), (11,5), (12,5), (10,6), (11,6), (12,6); frame_done on the 6th word; a 7th word lands at (10,5).
- Command 0x36 with 1 parameter, then RAMWR 1 word → cmd_code=0x36 then 0x2C; the pixel lands at (0,0); protocol_error=0.
- CASET 0,20,0,10 → protocol_error=1; a following RAMWR word produces no pixel_valid; pulsing LT24Reset_n low clears protocol_error.
- Write with LT24CS_n=1 → no output; write with LT24Rd_n=0 → protocol_error=1.
- With LT24_DECODER_CHECKSUM_EN: a 2×1 window with data 0xFFFF, 0x0002 → frame_sum=0x0001 after frame_done.
